kv_slab_allocator: RTL and testbench
====================================

# kv_slab_allocator

Fixed-slot value-memory allocator serving the request parser's malloc channel (16-bit byte size) and the store's free channel. It owns a free list of `NUM_SLOTS` equal-size slots and returns one slot base address per SET allocation. It arbitrates allocate and free requests onto a single-port free-list RAM, one operation per cycle.

## Interface
Parameters:
- `NUM_SLOTS`, 1024: slot count, power of 2, ≥ 4.
- `SLOT_BYTES`, 2048: bytes per slot, power of 2.
- `ADDR_WIDTH`, 32: address width.
- `BASE_ADDR`, 0: byte address of slot 0, `SLOT_BYTES`-aligned.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `s_alloc_size`  in  16  requested bytes.
- `s_alloc_valid`  in  1  allocate request valid.
- `s_alloc_ready`  out  1  allocate request accepted.
- `m_alloc_addr`  out  ADDR_WIDTH  granted slot base address; 0 on failure.
- `m_alloc_ok`  out  1  1 = granted, 0 = failed (oversize or empty).
- `m_alloc_valid`  out  1  response valid.
- `m_alloc_ready`  in  1  response consumed.
- `s_free_addr`  in  ADDR_WIDTH  slot base address being returned.
- `s_free_valid`  in  1  free request valid.
- `s_free_ready`  out  1  free request accepted.
- `init_done`  out  1  free list built.
- `free_count`  out  $clog2(NUM_SLOTS+1)  slots currently free.
- `err_bad_free`  out  1  one-cycle pulse when a free is dropped.

## Operation
- Free list: circular FIFO RAM of `NUM_SLOTS` entries, each `$clog2(NUM_SLOTS)` bits wide. Pointers `rd_ptr` and `wr_ptr` wrap modulo `NUM_SLOTS`; `free_count` ranges 0..`NUM_SLOTS`.
- States:
  - `ST_INIT`: write index i at entry i for i = 0..`NUM_SLOTS`-1, one per cycle, incrementing `free_count`. After the last write: `wr_ptr` = 0, `rd_ptr` = 0, `free_count` = `NUM_SLOTS`. Go to `ST_RUN`, set `init_done` = 1.
  - `ST_RUN`: serve requests.
  - No other states.
- Allocate (accepted in `ST_RUN`):
  - `s_alloc_size` > `SLOT_BYTES` → fail, free list untouched.
  - `free_count` == 0 → fail.
  - Otherwise pop the entry at `rd_ptr` and decrement `free_count`. Address = `BASE_ADDR` + slot × `SLOT_BYTES`.
  - Size 0 is a legal allocation and consumes one slot.
- Free:
  - slot = (`s_free_addr` − `BASE_ADDR`) / `SLOT_BYTES`.
  - Drop the request and pulse `err_bad_free` if any of these hold: address misaligned, below `BASE_ADDR`, slot ≥ `NUM_SLOTS`, or `free_count` == `NUM_SLOTS`.
  - Otherwise push the slot at `wr_ptr` and increment `free_count`.
  - Double frees with a valid address are not detected.
- Arbitration, at most one op per cycle:
  - Only one of alloc/free valid: grant it.
  - Both valid and `free_count` == 0: grant free.
  - Both valid otherwise: round-robin. Grant the side not granted last; `last_grant` updates only on an accepted op.
- Readies:
  - `s_alloc_ready` = `ST_RUN` & alloc granted & (!`m_alloc_valid` | `m_alloc_ready`).
  - `s_free_ready` = `ST_RUN` & free granted.
  - Readies may depend on valids; valids must not depend on readies.
- Response: a one-entry output register. It holds its value while `m_alloc_valid` & !`m_alloc_ready`; no further alloc is accepted until it drains. Frees proceed meanwhile.

## Timing
- Reset values: `m_alloc_valid` 0, `m_alloc_ok` 0, `m_alloc_addr` 0, `s_alloc_ready` 0, `s_free_ready` 0, `init_done` 0, `free_count` 0, `err_bad_free` 0; state `ST_INIT`, pointers 0, `last_grant` = free.
- Init takes exactly `NUM_SLOTS` cycles after reset deasserts. Both readies stay 0 until `init_done`.
- Alloc handshake at edge T → `m_alloc_valid` = 1 with `m_alloc_addr`/`m_alloc_ok` from edge T+1. `free_count` updates at T+1.
- Free handshake at edge T → `free_count` +1 at T+1; `err_bad_free` is high during cycle T+1 only for a dropped free.
- Back-to-back allocs at 1 per cycle when `m_alloc_ready` is held high and no free is pending.
- Free then alloc in consecutive cycles: the alloc can receive the just-freed slot when `free_count` was 0.
- Reset asserted mid-operation: everything returns to reset values within one edge, init reruns, and all outstanding allocations are forgotten.

## Test plan
- Reset with `NUM_SLOTS`=8, `SLOT_BYTES`=2048 → `init_done` rises exactly 8 cycles after `rst_n` high and `free_count` = 8.
- 8 allocs of size 100 with `m_alloc_ready` = 1 → addresses 0, 2048, …, 14336 at 1/cycle, all ok. A 9th alloc → ok = 0, addr = 0, `free_count` stays 0.
- From empty, free 4096 and alloc (size 64) asserted in the same cycle → free granted first, then alloc returns 4096 ok; `free_count` goes 0→1→0.
- Alloc size 2049 → ok = 0, `free_count` unchanged. Frees of 100, 16384 and (when full) 0 → each drops with an `err_bad_free` pulse and `free_count` unchanged.
- Continuous alloc and free contention for 20 cycles → grants alternate strictly. With `m_alloc_ready` held 0, the response stays stable and `s_alloc_ready` = 0 while frees are still accepted.
- Assert `rst_n` = 0 for 1 cycle after 3 allocs → outputs at reset values, init reruns, `free_count` returns to 8.

Source files
------------

// File: rtl/kv_slab_allocator.sv
// -----------------------------------------------------------------------------
// kv_slab_allocator
//
// Fixed-slot value-memory allocator. Keeps a circular free list of NUM_SLOTS
// equal-size slot indices and hands out one slot base address per allocate
// request. Allocate and free requests share the single write/read port of the
// free-list RAM, so at most one of them is accepted per cycle.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   s_alloc_size      requested byte count (0 is legal and consumes a slot)
//   s_alloc_valid     allocate request valid
//   s_alloc_ready     allocate request accepted this cycle
//   m_alloc_addr      granted slot base address, 0 on failure
//   m_alloc_ok        1 = granted, 0 = oversize request or list empty
//   m_alloc_valid     response valid (one-entry output register)
//   m_alloc_ready     response consumed
//   s_free_addr       slot base address being returned
//   s_free_valid      free request valid
//   s_free_ready      free request accepted this cycle
//   init_done         free list has been built
//   free_count        number of slots currently on the free list
//   err_bad_free      one-cycle pulse after an accepted free was dropped
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both high. A valid never depends on the matching ready; the
// readies here are combinational functions of the valids, the FSM state and
// the response register, and are only ever high in ST_RUN.
// -----------------------------------------------------------------------------
module kv_slab_allocator #(
    parameter int                    NUM_SLOTS  = 1024,
    parameter int                    SLOT_BYTES = 2048,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    s_alloc_size,
    input  logic                           s_alloc_valid,
    output logic                           s_alloc_ready,
    output logic [ADDR_WIDTH-1:0]          m_alloc_addr,
    output logic                           m_alloc_ok,
    output logic                           m_alloc_valid,
    input  logic                           m_alloc_ready,
    input  logic [ADDR_WIDTH-1:0]          s_free_addr,
    input  logic                           s_free_valid,
    output logic                           s_free_ready,
    output logic                           init_done,
    output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
    output logic                           err_bad_free
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int SHIFT = $clog2(SLOT_BYTES);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ADDR_WIDTH'(SLOT_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] SLOT_LIMIT   = ADDR_WIDTH'(NUM_SLOTS);
    localparam logic [CNT_W-1:0]      CNT_FULL     = CNT_W'(NUM_SLOTS);
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_SLOTS - 1);
    localparam logic [31:0]           SLOT_BYTES_U = 32'(SLOT_BYTES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_FREE  = 1'b0,
        GRANT_ALLOC = 1'b1
    } grant_t;

    state_t state;
    state_t state_next;
    grant_t last_grant;

    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;

    // Free-list storage. Read is combinational so a slot pushed by a free on
    // one edge can be popped by an alloc on the very next edge.
    logic [IDX_W-1:0] free_ram [NUM_SLOTS];
    logic             ram_we;
    logic [IDX_W-1:0] ram_wdata;

    // Arbitration
    logic alloc_eligible;
    logic grant_alloc;
    logic grant_free;
    logic alloc_fire;
    logic free_fire;

    // Allocate decode
    logic                  alloc_oversize;
    logic                  list_empty;
    logic                  list_full;
    logic                  alloc_pop;
    logic [ADDR_WIDTH-1:0] pop_addr;

    // Free decode
    logic [ADDR_WIDTH:0]   free_diff;
    logic [ADDR_WIDTH-1:0] free_off;
    logic                  free_below;
    logic                  free_misaligned;
    logic                  free_out_of_range;
    logic                  free_bad;
    logic                  free_push;
    logic [IDX_W-1:0]      free_slot;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign list_empty     = (free_count == '0);
    assign list_full      = (free_count == CNT_FULL);
    assign alloc_oversize = ({16'd0, s_alloc_size} > SLOT_BYTES_U);
    assign pop_addr       = BASE_ADDR + (ADDR_WIDTH'(free_ram[rd_ptr]) << SHIFT);

    // One extra bit on the subtraction: its borrow says the address lies
    // below BASE_ADDR, and the low bits are the byte offset into the pool.
    assign free_diff         = {1'b0, s_free_addr} - {1'b0, BASE_ADDR};
    assign free_below        = free_diff[ADDR_WIDTH];
    assign free_off          = free_diff[ADDR_WIDTH-1:0];
    assign free_misaligned   = ((free_off & ALIGN_MASK) != '0);
    assign free_out_of_range = ((free_off >> SHIFT) >= SLOT_LIMIT);
    assign free_slot         = IDX_W'(free_off >> SHIFT);
    assign free_bad          = free_below | free_misaligned | free_out_of_range | list_full;

    // -------------------------------------------------------------------------
    // FSM next state and arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        grant_alloc = 1'b0;
        grant_free  = 1'b0;
        // An alloc that cannot be accepted because the response register is
        // still occupied does not compete, so frees keep flowing meanwhile.
        alloc_eligible = s_alloc_valid && (!m_alloc_valid || m_alloc_ready);

        case (state)
            ST_INIT: begin
                if (wr_ptr == IDX_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_free_valid && alloc_eligible) begin
                    // With nothing to hand out the free goes first so the
                    // following alloc can succeed; otherwise alternate.
                    if (list_empty || (last_grant == GRANT_ALLOC)) begin
                        grant_free = 1'b1;
                    end else begin
                        grant_alloc = 1'b1;
                    end
                end else begin
                    grant_free  = s_free_valid;
                    grant_alloc = alloc_eligible;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign s_alloc_ready = grant_alloc;
    assign s_free_ready  = grant_free;
    assign alloc_fire    = s_alloc_valid && s_alloc_ready;
    assign free_fire     = s_free_valid && s_free_ready;
    assign alloc_pop     = alloc_fire && !alloc_oversize && !list_empty;
    assign free_push     = free_fire && !free_bad;

    // -------------------------------------------------------------------------
    // Free-list RAM write port: identity fill during init, pushes afterwards
    // -------------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = free_slot;
        if (rst_n) begin
            if (state == ST_INIT) begin
                ram_we    = 1'b1;
                ram_wdata = wr_ptr;
            end else if (free_push) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            free_ram[wr_ptr] <= ram_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // State, pointers, count and response register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            last_grant    <= GRANT_FREE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            free_count    <= '0;
            init_done     <= 1'b0;
            m_alloc_valid <= 1'b0;
            m_alloc_ok    <= 1'b0;
            m_alloc_addr  <= '0;
            err_bad_free  <= 1'b0;
        end else begin
            state        <= state_next;
            err_bad_free <= 1'b0;

            if (state == ST_INIT) begin
                // wr_ptr wraps back to 0 on the last fill write.
                wr_ptr     <= wr_ptr + IDX_W'(1);
                free_count <= free_count + CNT_W'(1);
                if (wr_ptr == IDX_LAST) begin
                    init_done <= 1'b1;
                end
            end else begin
                if (alloc_fire) begin
                    last_grant <= GRANT_ALLOC;
                end else if (free_fire) begin
                    last_grant <= GRANT_FREE;
                end

                if (alloc_pop) begin
                    rd_ptr     <= rd_ptr + IDX_W'(1);
                    free_count <= free_count - CNT_W'(1);
                end else if (free_push) begin
                    wr_ptr     <= wr_ptr + IDX_W'(1);
                    free_count <= free_count + CNT_W'(1);
                end

                if (free_fire && free_bad) begin
                    err_bad_free <= 1'b1;
                end
            end

            if (alloc_fire) begin
                m_alloc_valid <= 1'b1;
                m_alloc_ok    <= alloc_pop;
                m_alloc_addr  <= alloc_pop ? pop_addr : '0;
            end else if (m_alloc_ready) begin
                m_alloc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kv_slab_allocator.sv
// -----------------------------------------------------------------------------
// tb_kv_slab_allocator
//
// Bench for kv_slab_allocator with 8 slots of 2048 bytes at base 0. The
// reference model is a FIFO of free slot numbers plus the last granted side;
// allocate responses are predicted into exp_q and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_kv_slab_allocator;

    localparam int unsigned NS   = 8;
    localparam int unsigned SB   = 2048;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'd0;
    localparam int          CW   = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   s_alloc_size = '0;
    logic          s_alloc_valid = 1'b0;
    logic          s_alloc_ready;
    logic [AW-1:0] m_alloc_addr;
    logic          m_alloc_ok;
    logic          m_alloc_valid;
    logic          m_alloc_ready = 1'b1;
    logic [AW-1:0] s_free_addr = '0;
    logic          s_free_valid = 1'b0;
    logic          s_free_ready;
    logic          init_done;
    logic [CW-1:0] free_count;
    logic          err_bad_free;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    kv_slab_allocator #(
        .NUM_SLOTS (NS),
        .SLOT_BYTES(SB),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_alloc_size (s_alloc_size),
        .s_alloc_valid(s_alloc_valid),
        .s_alloc_ready(s_alloc_ready),
        .m_alloc_addr (m_alloc_addr),
        .m_alloc_ok   (m_alloc_ok),
        .m_alloc_valid(m_alloc_valid),
        .m_alloc_ready(m_alloc_ready),
        .s_free_addr  (s_free_addr),
        .s_free_valid (s_free_valid),
        .s_free_ready (s_free_ready),
        .init_done    (init_done),
        .free_count   (free_count),
        .err_bad_free (err_bad_free)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];          // {ok, addr}
    int unsigned model_fl[$];       // free slot numbers, oldest first
    bit          model_last_alloc;  // last accepted op was an alloc
    bit          exp_err;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        model_fl.delete();
        for (int i = 0; i < int'(NS); i++) model_fl.push_back(i);
        model_last_alloc = 1'b0;
    endtask

    task automatic model_alloc(input int unsigned size);
        int unsigned s;
        if (size > SB || model_fl.size() == 0) begin
            exp_q.push_back({1'b0, 32'd0});
        end else begin
            s = model_fl.pop_front();
            exp_q.push_back({1'b1, BASE + s * SB});
        end
    endtask

    task automatic model_free(input logic [31:0] addr);
        int unsigned off;
        off = addr - BASE;
        if (longint'(addr) < longint'(BASE) || (off % SB) != 0 || (off / SB) >= NS
            || model_fl.size() == int'(NS)) begin
            exp_err = 1'b1;
        end else begin
            model_fl.push_back(off / SB);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && m_alloc_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected actual={%0b,%0h} required=none @%0t",
                         m_alloc_ok, m_alloc_addr, $time);
            end else begin
                check("alloc_resp", 64'({m_alloc_ok, m_alloc_addr}), 64'(exp_q[0]));
                if (m_alloc_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle of stimulus: present the requests, see what was accepted at
    // the coming edge, update the model, then check count and error pulse.
    task automatic cycle_op(input bit av, input int unsigned size, input bit fv,
                            input logic [31:0] faddr, input bit chk,
                            output bit a_acc, output bit f_acc);
        bit ea;
        bit ef;
        s_alloc_valid = av;
        s_alloc_size  = 16'(size);
        s_free_valid  = fv;
        s_free_addr   = faddr;
        ea = av && (!fv || (model_fl.size() != 0 && !model_last_alloc));
        ef = fv && !ea;
        @(negedge clk);
        a_acc = av && s_alloc_ready;
        f_acc = fv && s_free_ready;
        if (chk) begin
            check("grant_alloc", 64'(a_acc), 64'(ea));
            check("grant_free", 64'(f_acc), 64'(ef));
        end
        exp_err = 1'b0;
        if (a_acc) begin
            model_alloc(size);
            model_last_alloc = 1'b1;
        end
        if (f_acc) begin
            model_free(faddr);
            model_last_alloc = 1'b0;
        end
        @(posedge clk);
        #1;
        s_alloc_valid = 1'b0;
        s_free_valid  = 1'b0;
        check("free_count", 64'(free_count), 64'(model_fl.size()));
        check("err_bad_free", 64'(err_bad_free), 64'(exp_err));
    endtask

    task automatic check_reset_values();
        check("rst_m_alloc_valid", 64'(m_alloc_valid), 64'(0));
        check("rst_m_alloc_ok", 64'(m_alloc_ok), 64'(0));
        check("rst_m_alloc_addr", 64'(m_alloc_addr), 64'(0));
        check("rst_s_alloc_ready", 64'(s_alloc_ready), 64'(0));
        check("rst_s_free_ready", 64'(s_free_ready), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_free_count", 64'(free_count), 64'(0));
        check("rst_err_bad_free", 64'(err_bad_free), 64'(0));
    endtask

    // Release reset and count cycles to init_done, with both requests held
    // so the readies are exercised while the list is being built.
    task automatic wait_init();
        int k;
        s_alloc_valid = 1'b1;
        s_alloc_size  = 16'd100;
        s_free_valid  = 1'b1;
        s_free_addr   = 32'd0;
        rst_n = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (init_done) break;
            @(negedge clk);
            check("ready_in_init", 64'({s_alloc_ready, s_free_ready}), 64'(0));
        end
        s_alloc_valid = 1'b0;
        s_free_valid  = 1'b0;
        check("init_latency", 64'(k), 64'(NS));
        check("count_after_init", 64'(free_count), 64'(NS));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          a;
        bit          f;
        int unsigned slots[$];
        int unsigned j;
        int unsigned tmp;
        int unsigned sz;
        logic [31:0] fa;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        model_reset();
        mon_en = 1'b1;
        wait_init();

        // Fill: eight allocs back to back, then one on an empty list.
        for (int i = 0; i < 8; i++) begin
            cycle_op(1'b1, 100, 1'b0, 32'd0, 1'b0, a, f);
            check("alloc_accept", 64'(a), 64'(1));
        end
        cycle_op(1'b1, 100, 1'b0, 32'd0, 1'b0, a, f);
        check("alloc_empty_accept", 64'(a), 64'(1));

        // Empty list: free and alloc together, free must win.
        cycle_op(1'b1, 64, 1'b1, 32'd4096, 1'b1, a, f);
        cycle_op(1'b1, 64, 1'b0, 32'd0, 1'b0, a, f);
        check("alloc_after_free", 64'(a), 64'(1));

        // Oversize and bad frees.
        cycle_op(1'b0, 0, 1'b1, 32'd2048, 1'b0, a, f);
        cycle_op(1'b1, 2049, 1'b0, 32'd0, 1'b0, a, f);
        cycle_op(1'b0, 0, 1'b1, 32'd100, 1'b0, a, f);
        cycle_op(1'b0, 0, 1'b1, 32'd16384, 1'b0, a, f);

        // Return the remaining slots in a random order until full.
        slots.delete();
        for (int i = 0; i < 8; i++) if (i != 1) slots.push_back(i);
        for (int i = slots.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = slots[i];
            slots[i] = slots[j];
            slots[j] = tmp;
        end
        foreach (slots[i]) cycle_op(1'b0, 0, 1'b1, slots[i] * SB, 1'b0, a, f);
        cycle_op(1'b0, 0, 1'b1, 32'd0, 1'b0, a, f);

        // Contention with random sizes and addresses.
        for (int i = 0; i < 20; i++) begin
            sz = $urandom_range(0, 2100);
            fa = $urandom_range(0, 9) * SB;
            if ($urandom_range(0, 3) == 0) fa = fa + $urandom_range(1, SB - 1);
            cycle_op(1'b1, sz, 1'b1, fa, 1'b1, a, f);
        end

        // Stalled response: held stable, allocs blocked, frees still flow.
        m_alloc_ready = 1'b0;
        cycle_op(1'b1, 100, 1'b0, 32'd0, 1'b0, a, f);
        check("stall_first_accept", 64'(a), 64'(1));
        for (int i = 0; i < 4; i++) begin
            fa = $urandom_range(0, NS - 1) * SB;
            cycle_op(1'b1, 100, 1'b1, fa, 1'b0, a, f);
            check("stall_alloc_blocked", 64'(a), 64'(0));
            check("stall_free_accept", 64'(f), 64'(1));
        end
        m_alloc_ready = 1'b1;
        cycle_op(1'b0, 0, 1'b0, 32'd0, 1'b0, a, f);

        // Mid-operation reset after three allocs.
        for (int i = 0; i < 3; i++) cycle_op(1'b1, 100, 1'b0, 32'd0, 1'b0, a, f);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();
        exp_q.delete();
        model_reset();
        wait_init();
        cycle_op(1'b1, 0, 1'b0, 32'd0, 1'b0, a, f);
        check("alloc_after_reset", 64'(a), 64'(1));
        cycle_op(1'b0, 0, 1'b0, 32'd0, 1'b0, a, f);

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
